// File: rtl/fixed3_ray_param_solve.sv
// Recovers t from p = o + t*d on the axis with the largest |d|, using a fixed-latency
// radix-2 restoring divider between valid/ready handshakes.
//
// state  | meaning
// IDLE   | waiting for in_valid; operands latched on accept
// SELECT | pick axis, form magnitudes, sign, dz and ovf flags
// DIVIDE | one quotient bit per cycle, WIDTH cycles
// DONE   | result presented, held until out_ready
module fixed3_ray_param_solve #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3*WIDTH-1:0]   p,
    input  logic [3*WIDTH-1:0]   o,
    input  logic [3*WIDTH-1:0]   d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_t,
    output logic [1:0]           out_axis,
    output logic                 out_dz,
    output logic                 out_ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_DIVIDE, S_DONE} state_t;
    state_t state, state_nxt;

    logic [3*WIDTH-1:0] p_r, o_r, d_r;
    logic [WIDTH-1:0]   abs_d [3];
    logic [1:0]         sel_k;
    logic [WIDTH-1:0]   pk, ok, dk;
    logic [WIDTH:0]     num, mag_n_w;
    logic [2*WIDTH-1:0] ovf_lhs, ovf_rhs;

    logic [WIDTH-1:0]   mag_d, dlow, q, q_nxt;
    logic [WIDTH+1:0]   rem, rem_nxt;
    logic [WIDTH+2:0]   shifted;
    logic               ge;
    logic [CW-1:0]      cnt;
    logic               sign, dz, ovf;
    logic [1:0]         axis;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            abs_d[i] = d_r[i*WIDTH+WIDTH-1] ? -d_r[i*WIDTH +: WIDTH] : d_r[i*WIDTH +: WIDTH];
        end
        sel_k = 2'd0;
        if (abs_d[1] > abs_d[0])
            sel_k = 2'd1;
        if (abs_d[2] > abs_d[sel_k])
            sel_k = 2'd2;
        pk = p_r[int'(sel_k)*WIDTH +: WIDTH];
        ok = o_r[int'(sel_k)*WIDTH +: WIDTH];
        dk = d_r[int'(sel_k)*WIDTH +: WIDTH];
        // One extra bit so p - o cannot wrap.
        num     = {pk[WIDTH-1], pk} - {ok[WIDTH-1], ok};
        mag_n_w = num[WIDTH] ? -num : num;
        ovf_lhs = {{(WIDTH-FRAC-1){1'b0}}, mag_n_w, {FRAC{1'b0}}};
        ovf_rhs = {1'b0, abs_d[sel_k], {(WIDTH-1){1'b0}}};
    end

    // Remainder stays below 2*mag_d when no overflow, so WIDTH+2 bits suffice.
    always_comb begin
        shifted = {rem, dlow[WIDTH-1]};
        ge      = shifted >= {3'b000, mag_d};
        rem_nxt = ge ? (WIDTH+2)'(shifted - {3'b000, mag_d}) : (WIDTH+2)'(shifted);
        q_nxt   = (q << 1) | WIDTH'(ge);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = S_SELECT;
            end
            S_SELECT: state_nxt = S_DIVIDE;
            S_DIVIDE: if (cnt == '0) state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_r      <= '0;
            o_r      <= '0;
            d_r      <= '0;
            mag_d    <= '0;
            dlow     <= '0;
            q        <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
            axis     <= 2'd0;
            out_t    <= '0;
            out_axis <= 2'd0;
            out_dz   <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        p_r <= p;
                        o_r <= o;
                        d_r <= d;
                    end
                end
                S_SELECT: begin
                    axis  <= sel_k;
                    mag_d <= abs_d[sel_k];
                    sign  <= num[WIDTH] ^ dk[WIDTH-1];
                    dz    <= (abs_d[sel_k] == '0);
                    ovf   <= (abs_d[sel_k] != '0) && (ovf_lhs >= ovf_rhs);
                    // Dividend is mag_n << FRAC: its top bits seed the remainder.
                    rem   <= {{(WIDTH+1-FRAC){1'b0}}, mag_n_w[WIDTH:WIDTH-FRAC]};
                    dlow  <= {mag_n_w[WIDTH-FRAC-1:0], {FRAC{1'b0}}};
                    q     <= '0;
                    cnt   <= CW'(WIDTH-1);
                end
                S_DIVIDE: begin
                    rem  <= rem_nxt;
                    dlow <= dlow << 1;
                    q    <= q_nxt;
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        out_axis <= axis;
                        out_dz   <= dz;
                        out_ovf  <= !dz && ovf;
                        if (dz)
                            out_t <= {1'b0, {(WIDTH-1){1'b1}}};
                        else if (ovf)
                            out_t <= sign ? {1'b1, {(WIDTH-2){1'b0}}, 1'b1} : {1'b0, {(WIDTH-1){1'b1}}};
                        else
                            out_t <= sign ? -q_nxt : q_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed3_ray_param_solve.sv
// Bench for fixed3_ray_param_solve: arithmetic reference model, per-cycle scoreboard
// compare on the falling edge, directed literal cases and randomized traffic.
module tb_fixed3_ray_param_solve;
    localparam int W   = 32;
    localparam int F   = 16;
    localparam int LAT = 34;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3*W-1:0] p = '0, o = '0, d = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_t;
    logic [1:0]    out_axis;
    logic          out_dz, out_ovf;

    fixed3_ray_param_solve #(.WIDTH(W), .FRAC(F)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p(p), .o(o), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .out_t(out_t), .out_axis(out_axis), .out_dz(out_dz), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] t;
        logic [1:0]   axis;
        logic         dz;
        logic         ovf;
        longint       acc;
        logic         seen;
    } res_t;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    res_t   sbq[$];
    int     n_done = 0;
    logic [W-1:0] last_t;
    logic [1:0]   last_axis;
    logic         last_dz, last_ovf;
    longint       last_lat = 0;
    logic         rand_mode = 1'b0;
    logic         or_manual = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3*W-1:0] vec3(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c);
        return {c, b, a};
    endfunction

    // t = (p_k - o_k) / d_k in fixed point, from plain integer arithmetic.
    function automatic res_t model(input logic [3*W-1:0] pv, input logic [3*W-1:0] ov,
                                   input logic [3*W-1:0] dv);
        res_t   r;
        longint ad [3];
        longint di, num, mn, dks, q;
        int     k;
        logic   neg;
        for (int i = 0; i < 3; i++) begin
            di = longint'($signed(dv[i*W +: W]));
            ad[i] = (di < 0) ? -di : di;
        end
        k = 0;
        if (ad[1] > ad[k]) k = 1;
        if (ad[2] > ad[k]) k = 2;
        num = longint'($signed(pv[k*W +: W])) - longint'($signed(ov[k*W +: W]));
        dks = longint'($signed(dv[k*W +: W]));
        neg = (num < 0) != (dks < 0);
        mn  = (num < 0) ? -num : num;
        r.axis = 2'(k);
        r.dz   = 1'b0;
        r.ovf  = 1'b0;
        r.acc  = 0;
        r.seen = 1'b0;
        if (ad[k] == 0) begin
            r.dz = 1'b1;
            r.t  = 32'h7FFF_FFFF;
        end else if ((mn << F) >= (ad[k] << (W-1))) begin
            r.ovf = 1'b1;
            r.t   = neg ? 32'h8000_0001 : 32'h7FFF_FFFF;
        end else begin
            q   = (mn << F) / ad[k];
            r.t = neg ? 32'(-q) : 32'(q);
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rand_mode) out_ready = 1'($urandom % 2);
        else out_ready = or_manual;
    end

    // Scoreboard compare on every falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            chk("in_ready", 64'(in_ready), 64'(sbq.size() == 0));
            chk("out_valid", 64'(out_valid),
                64'(sbq.size() > 0 && (cyc - sbq[0].acc) >= LAT));
            if (out_valid && sbq.size() > 0) begin
                if (!sbq[0].seen) begin
                    last_lat = cyc - sbq[0].acc;
                    sbq[0].seen = 1'b1;
                end
                chk("out_t", 64'(out_t), 64'(sbq[0].t));
                chk("out_axis", 64'(out_axis), 64'(sbq[0].axis));
                chk("out_dz", 64'(out_dz), 64'(sbq[0].dz));
                chk("out_ovf", 64'(out_ovf), 64'(sbq[0].ovf));
                if (out_ready) begin
                    last_t    = out_t;
                    last_axis = out_axis;
                    last_dz   = out_dz;
                    last_ovf  = out_ovf;
                    void'(sbq.pop_front());
                    n_done++;
                end
            end
            if (in_valid && in_ready) begin
                res_t r;
                r = model(p, o, d);
                r.acc = cyc;
                sbq.push_back(r);
            end
        end
    end

    task automatic send(input logic [3*W-1:0] pv, input logic [3*W-1:0] ov,
                        input logic [3*W-1:0] dv);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        p = pv;
        o = ov;
        d = dv;
        while (!acc && n < 300) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        p = {$urandom, $urandom, $urandom};
        o = {$urandom, $urandom, $urandom};
        d = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (n_done < target && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n_done < target) chk("done_timeout", 64'(n_done), 64'(target));
    endtask

    task automatic directed(input string name, input logic [3*W-1:0] pv, input logic [3*W-1:0] ov,
                            input logic [3*W-1:0] dv, input logic [W-1:0] et, input logic [1:0] ea,
                            input logic edz, input logic eovf);
        res_t r;
        int   tgt;
        r = model(pv, ov, dv);
        chk({name, "_model_t"}, 64'(r.t), 64'(et));
        chk({name, "_model_axis"}, 64'(r.axis), 64'(ea));
        tgt = n_done + 1;
        send(pv, ov, dv);
        wait_done(tgt);
        chk({name, "_t"}, 64'(last_t), 64'(et));
        chk({name, "_axis"}, 64'(last_axis), 64'(ea));
        chk({name, "_dz"}, 64'(last_dz), 64'(edz));
        chk({name, "_ovf"}, 64'(last_ovf), 64'(eovf));
        chk({name, "_latency"}, 64'(last_lat), 64'(LAT));
    endtask

    function automatic logic [W-1:0] rcomp();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = $urandom;
            2: begin
                v = $urandom_range(0, 32'h0003_FFFF);
                if ($urandom % 2) v = -v;
            end
            3: begin
                v = $urandom;
                v = W'($signed(v) >>> $urandom_range(0, 31));
            end
            4: v = ($urandom % 2) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: v = 32'(($urandom_range(1, 8) << F)) ^ (($urandom % 2) ? 32'hFFFF_FFFF : 32'h0);
        endcase
        return v;
    endfunction

    initial begin
        #95_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [3*W-1:0] rp, ro, rd;
        int             tgt, n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_t", 64'(out_t), 64'd0);
        chk("rst_out_axis", 64'(out_axis), 64'd0);
        chk("rst_flags", 64'({out_dz, out_ovf}), 64'd0);
        @(posedge clk);
        #1;

        directed("t1", vec3(32'h0003_8000, 0, 0), '0, vec3(32'h0001_0000, 0, 0),
                 32'h0003_8000, 2'd0, 1'b0, 1'b0);
        directed("t2", vec3(0, 0, 32'hFFFF_0000), vec3(0, 0, 32'h0001_0000),
                 vec3(0, 32'h0000_4000, 32'h0000_8000), 32'hFFFC_0000, 2'd2, 1'b0, 1'b0);
        directed("t3_tie", vec3(32'h0001_0000, 32'h0003_0000, 0), '0,
                 vec3(32'h0002_0000, 32'hFFFE_0000, 32'h0001_0000), 32'h0000_8000, 2'd0, 1'b0, 1'b0);
        directed("t4_dz", vec3(32'h1234_5678, 1, 2), vec3(5, 6, 7), '0,
                 32'h7FFF_FFFF, 2'd0, 1'b1, 1'b0);
        directed("t4_ovf", vec3(32'hFFFF_0000, 0, 0), '0, vec3(1, 0, 0),
                 32'h8000_0001, 2'd0, 1'b0, 1'b1);
        directed("zero_q", vec3(32'h0001_2345, 0, 0), vec3(32'h0001_2345, 0, 0),
                 vec3(32'hFFFF_0000, 0, 0), 32'h0000_0000, 2'd0, 1'b0, 1'b0);

        // Backpressure: result held for 10 cycles while new inputs are offered.
        or_manual = 1'b0;
        @(posedge clk);
        #1;
        tgt = n_done + 1;
        send(vec3(32'h0003_8000, 0, 0), '0, vec3(32'h0001_0000, 0, 0));
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_reach_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            p = {$urandom, $urandom, $urandom};
            d = {$urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_t", 64'(out_t), 64'h0003_8000);
        end
        in_valid = 1'b0;
        or_manual = 1'b1;
        @(posedge clk);
        #1;
        or_manual = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_one_transfer", 64'(n_done), 64'(tgt));
        chk("bp_after_valid", 64'(out_valid), 64'd0);
        chk("bp_after_in_ready", 64'(in_ready), 64'd1);
        or_manual = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of DIVIDE drops the in-flight result.
        send(vec3(32'h0003_8000, 0, 0), '0, vec3(32'h0001_0000, 0, 0));
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        directed("post_rst", vec3(32'h0001_0000, 32'h0003_0000, 0), '0,
                 vec3(32'h0002_0000, 32'hFFFE_0000, 32'h0001_0000), 32'h0000_8000, 2'd0, 1'b0, 1'b0);

        // Randomized traffic with random consumer backpressure.
        rand_mode = 1'b1;
        tgt = n_done;
        for (int v = 0; v < 1000; v++) begin
            rp = {rcomp(), rcomp(), rcomp()};
            ro = {rcomp(), rcomp(), rcomp()};
            rd = {rcomp(), rcomp(), rcomp()};
            if ($urandom % 8 == 0) rd[W +: W] = -rd[0 +: W];
            if ($urandom % 8 == 0) rd[2*W +: W] = rd[W +: W];
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(rp, ro, rd);
            tgt++;
        end
        rand_mode = 1'b0;
        or_manual = 1'b1;
        wait_done(tgt);
        chk("rand_all_done", 64'(n_done), 64'(tgt));
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
